// File: rtl/seg_pkg.sv
// Shared types and the hex-to-segment table for the 4-digit seven-segment scanner.
package seg_pkg;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

    // Word latched by number_vld and later shown for a whole frame.
    typedef struct packed {
        logic [15:0] number;
        logic [3:0]  dot;
        logic        lz_en;
    } disp_word_t;

    // Segment order g..a (bit6..bit0); entry 15 first so HEX7_TABLE[n] decodes nibble n.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex7_dec.sv
// Combinational nibble to seven-segment decode (active-high, a=bit0 .. g=bit6).
module hex7_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = HEX7_TABLE[nibble];

endmodule

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed seven-segment driver with blanking gaps, leading-zero
// suppression and frame-aligned (tear-free) display updates.
module seg7_scan4 #(
    parameter int PRESCALE     = 12500,
    parameter int BLANK_CYCLES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] number,
    input  logic [3:0]  dot,
    input  logic        number_vld,
    input  logic        lz_en,
    output logic [3:0]  sel,
    output logic [7:0]  seg,
    output logic        frame_done
);
    import seg_pkg::*;

    localparam logic        POL        = (ACTIVE_LOW != 0);
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
    localparam logic [7:0]  GAP_LAST   = 8'(BLANK_CYCLES - 1);

    scan_state_t state_reg, state_next;
    logic [1:0]  idx_reg, idx_next;
    logic [15:0] presc_reg, presc_next;
    logic [7:0]  gap_reg, gap_next;
    disp_word_t  shadow_reg, shadow_next;
    disp_word_t  pending_reg, pending_next;
    logic        pend_flag_reg, pend_flag_next;
    logic [3:0]  sel_reg;
    logic [7:0]  seg_reg;
    logic        frame_done_reg;

    disp_word_t  incoming;
    logic        boundary;

    assign incoming = {number, dot, lz_en};
    assign boundary = (state_reg == GAP) && (gap_reg == GAP_LAST) && (idx_reg == 2'd3);

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        presc_next     = presc_reg;
        gap_next       = gap_reg;
        shadow_next    = shadow_reg;
        pending_next   = pending_reg;
        pend_flag_next = pend_flag_reg;

        case (state_reg)
            SHOW: begin
                if (presc_reg == PRESC_LAST) begin
                    state_next = GAP;
                    gap_next   = '0;
                end else begin
                    presc_next = presc_reg + 16'd1;
                end
            end
            default: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = SHOW;
                    idx_next   = idx_reg + 2'd1;
                    presc_next = '0;
                end else begin
                    gap_next = gap_reg + 8'd1;
                end
            end
        endcase

        if (number_vld) begin
            pending_next   = incoming;
            pend_flag_next = 1'b1;
        end

        // A load arriving on the boundary edge itself bypasses the pending stage.
        if (boundary) begin
            if (number_vld) begin
                shadow_next = incoming;
            end else if (pend_flag_reg) begin
                shadow_next = pending_reg;
            end
            pend_flag_next = 1'b0;
        end
    end

    // Per-digit leading-zero blank flags, evaluated on the word about to be shown.
    logic [3:0] blank_vec;
    assign blank_vec[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_blank
            assign blank_vec[gi] = shadow_next.lz_en && (shadow_next.number[15:4*gi] == '0);
        end
    endgenerate

    logic [3:0] cur_nibble;
    logic [6:0] dec_segs;
    logic [3:0] sel_log;
    logic [7:0] seg_log;

    assign cur_nibble = shadow_next.number[{idx_next, 2'b00} +: 4];

    hex7_dec u_dec (
        .nibble (cur_nibble),
        .segs   (dec_segs)
    );

    always_comb begin
        sel_log = '0;
        seg_log = '0;
        if (state_next == SHOW) begin
            sel_log[idx_next] = 1'b1;
            seg_log = {shadow_next.dot[idx_next], blank_vec[idx_next] ? 7'd0 : dec_segs};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= GAP;
            idx_reg        <= 2'd3;
            presc_reg      <= '0;
            gap_reg        <= '0;
            shadow_reg     <= '0;
            pending_reg    <= '0;
            pend_flag_reg  <= 1'b0;
            sel_reg        <= {4{POL}};
            seg_reg        <= {8{POL}};
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            presc_reg      <= presc_next;
            gap_reg        <= gap_next;
            shadow_reg     <= shadow_next;
            pending_reg    <= pending_next;
            pend_flag_reg  <= pend_flag_next;
            sel_reg        <= sel_log ^ {4{POL}};
            seg_reg        <= seg_log ^ {8{POL}};
            frame_done_reg <= boundary;
        end
    end

    assign sel        = sel_reg;
    assign seg        = seg_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan4.sv
// Self-checking bench for seg7_scan4: frame-position reference model, two polarities.
module tb_seg7_scan4;

    localparam int P = 4;
    localparam int B = 2;
    localparam int F = 4 * (P + B);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] number = '0;
    logic [3:0]  dot = '0;
    logic        number_vld = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  sel, sel_al;
    logic [7:0]  seg, seg_al;
    logic        frame_done, fd_al;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: edges since reset release, frame-level shadow/pending words.
    int          n_edge = 0;
    int          m_pos = -1;
    logic [20:0] m_shadow = '0;
    logic [20:0] m_pend_val = '0;
    bit          m_pend = 0;
    logic [3:0]  exp_sel;
    logic [7:0]  exp_seg;
    logic        exp_fd;
    logic [6:0]  tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan4 #(.PRESCALE(P), .BLANK_CYCLES(B), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .number(number), .dot(dot), .number_vld(number_vld),
        .lz_en(lz_en), .sel(sel), .seg(seg), .frame_done(frame_done)
    );

    seg7_scan4 #(.PRESCALE(P), .BLANK_CYCLES(B), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst(rst), .number(number), .dot(dot), .number_vld(number_vld),
        .lz_en(lz_en), .sel(sel_al), .seg(seg_al), .frame_done(fd_al)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs, clock it, and advance the reference model.
    task automatic tick(input bit r, input bit vld, input logic [15:0] num,
                        input logic [3:0] dt, input bit lz);
        logic [20:0] inw;
        logic [15:0] sn;
        logic [3:0]  sd;
        int d, w;
        bit blank;
        rst = r; number_vld = vld; number = num; dot = dt; lz_en = lz;
        inw = {num, dt, lz};
        @(posedge clk);
        if (r) begin
            n_edge = 0; m_shadow = '0; m_pend = 0; m_pend_val = '0;
        end else begin
            n_edge++;
            if (n_edge >= B && (n_edge - B) % F == 0) begin
                if (vld) m_shadow = inw;
                else if (m_pend) m_shadow = m_pend_val;
                m_pend = 0;
            end else if (vld) begin
                m_pend_val = inw;
                m_pend = 1;
            end
        end
        exp_sel = '0; exp_seg = '0; exp_fd = 1'b0; m_pos = -1;
        if (!r && n_edge >= B) begin
            m_pos  = (n_edge - B) % F;
            exp_fd = (m_pos == 0);
            d = m_pos / (P + B);
            w = m_pos % (P + B);
            if (w < P) begin
                sn = m_shadow[20:5];
                sd = m_shadow[4:1];
                blank = m_shadow[0] && d > 0 && ((sn >> (4 * d)) == 0);
                exp_sel = 4'(1 << d);
                exp_seg = {sd[d], blank ? 7'h00 : tbl[(sn >> (4 * d)) & 16'hF]};
            end
        end
        #1;
        number_vld = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tick(1, 0, 16'h0, 4'h0, 0);
            n_cmp++;
            if (sel !== 4'h0 || seg !== 8'h00 || frame_done !== 1'b0 ||
                sel_al !== 4'hF || seg_al !== 8'hFF || fd_al !== 1'b0) begin
                n_bad++;
                $display("FAIL reset: sel=%b seg=%h fd=%b al_sel=%b al_seg=%h required 0000/00/0 and 1111/ff",
                         sel, seg, frame_done, sel_al, seg_al);
            end
        end
        $display("reset: %0d cycles held", 3);
    endtask

    task automatic test_idle();
        int pulses = 0;
        for (int k = 0; k < 3 * F + B; k++) begin
            tick(0, 0, 16'h0, 4'h0, 0);
            pulses += int'(frame_done === 1'b1);
            n_cmp++;
            if ({sel, seg, frame_done} !== {exp_sel, exp_seg, exp_fd} ||
                {sel_al, seg_al, fd_al} !== {~exp_sel, ~exp_seg, exp_fd}) begin
                n_bad++;
                $display("FAIL idle cyc=%0d: sel=%b seg=%h fd=%b al=%b/%h required sel=%b seg=%h fd=%b",
                         k, sel, seg, frame_done, sel_al, seg_al, exp_sel, exp_seg, exp_fd);
            end
            if (k == B - 1) begin
                n_cmp++;
                if (sel !== 4'b0001 || seg !== 8'h3F || frame_done !== 1'b1) begin
                    n_bad++;
                    $display("FAIL first_digit: sel=%b seg=%h fd=%b required 0001/3f/1", sel, seg, frame_done);
                end
            end
        end
        n_cmp++;
        if (pulses != 4) begin
            n_bad++;
            $display("FAIL frame_count: pulses=%0d required 4", pulses);
        end
        $display("idle: %0d frame pulses", pulses);
    endtask

    task automatic test_midframe_load();
        logic [7:0] want [4] = '{8'hF1, 8'h77, 8'h5B, 8'h06};
        bit loaded = 0;
        int frames_after = 0;
        for (int k = 0; k < 3 * F; k++) begin
            bit go;
            go = !loaded && m_pos == 9;
            tick(0, go, 16'h12AF, 4'b0001, 0);
            if (go) begin
                loaded = 1;
                $display("load 12af dot=0001 at pos=%0d", m_pos);
            end
            if (loaded && m_pos == 0) frames_after++;
            n_cmp++;
            if ({sel, seg, frame_done} !== {exp_sel, exp_seg, exp_fd} ||
                {sel_al, seg_al, fd_al} !== {~exp_sel, ~exp_seg, exp_fd}) begin
                n_bad++;
                $display("FAIL midframe cyc=%0d: sel=%b seg=%h fd=%b al=%b/%h required sel=%b seg=%h fd=%b",
                         k, sel, seg, frame_done, sel_al, seg_al, exp_sel, exp_seg, exp_fd);
            end
            if (frames_after == 1 && m_pos % (P + B) == 0) begin
                n_cmp++;
                if (seg !== want[m_pos / (P + B)]) begin
                    n_bad++;
                    $display("FAIL midframe_digit%0d: seg=%h required %h",
                             m_pos / (P + B), seg, want[m_pos / (P + B)]);
                end
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] vals [2] = '{16'h0050, 16'h0000};
        for (int v = 0; v < 2; v++) begin
            for (int k = 0; k < 2 * F; k++) begin
                tick(0, k == 0, vals[v], 4'h0, 1);
                if (k == 0) $display("load %h lz_en=1 at pos=%0d", vals[v], m_pos);
                n_cmp++;
                if ({sel, seg, frame_done} !== {exp_sel, exp_seg, exp_fd} ||
                    {sel_al, seg_al, fd_al} !== {~exp_sel, ~exp_seg, exp_fd}) begin
                    n_bad++;
                    $display("FAIL lz_blank val=%h cyc=%0d: sel=%b seg=%h fd=%b required sel=%b seg=%h fd=%b",
                             vals[v], k, sel, seg, frame_done, exp_sel, exp_seg, exp_fd);
                end
            end
        end
    endtask

    task automatic test_boundary_load();
        bit done = 0;
        for (int k = 0; k < 3 * F; k++) begin
            bit go;
            go = !done && m_pos == F - 1;
            tick(0, go, 16'hBEEF, 4'b1010, 0);
            n_cmp++;
            if ({sel, seg, frame_done} !== {exp_sel, exp_seg, exp_fd} ||
                {sel_al, seg_al, fd_al} !== {~exp_sel, ~exp_seg, exp_fd}) begin
                n_bad++;
                $display("FAIL boundary_load cyc=%0d: sel=%b seg=%h fd=%b required sel=%b seg=%h fd=%b",
                         k, sel, seg, frame_done, exp_sel, exp_seg, exp_fd);
            end
            if (go) begin
                done = 1;
                $display("load beef on boundary edge, pos now=%0d", m_pos);
                n_cmp++;
                if (dut.pend_flag_reg !== 1'b0 || frame_done !== 1'b1) begin
                    n_bad++;
                    $display("FAIL boundary_pending: flag=%b fd=%b required flag=0 fd=1",
                             dut.pend_flag_reg, frame_done);
                end
            end
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL boundary_bound: boundary edge not reached, required reached");
        end
    endtask

    task automatic test_random();
        int loads = 0;
        for (int k = 0; k < 600; k++) begin
            bit vld;
            logic [15:0] num;
            vld = ($urandom_range(0, 7) == 0);
            num = 16'($urandom);
            if ($urandom_range(0, 1) == 0) num = num & 16'h00FF;
            tick(0, vld, num, 4'($urandom), 1'($urandom));
            loads += int'(vld);
            n_cmp++;
            if ({sel, seg, frame_done} !== {exp_sel, exp_seg, exp_fd} ||
                {sel_al, seg_al, fd_al} !== {~exp_sel, ~exp_seg, exp_fd}) begin
                n_bad++;
                $display("FAIL random cyc=%0d num=%h: sel=%b seg=%h fd=%b al=%b/%h required sel=%b seg=%h fd=%b",
                         k, num, sel, seg, frame_done, sel_al, seg_al, exp_sel, exp_seg, exp_fd);
            end
        end
        $display("random: %0d loads over 600 cycles", loads);
    endtask

    task automatic test_reset_mid();
        bit done = 0;
        for (int k = 0; k < 4 * F; k++) begin
            bit go;
            go = !done && m_pos >= 0 && m_pos / (P + B) == 2 && m_pos % (P + B) == 1;
            tick(go, 0, 16'h0, 4'h0, 0);
            n_cmp++;
            if ({sel, seg, frame_done} !== {exp_sel, exp_seg, exp_fd} ||
                {sel_al, seg_al, fd_al} !== {~exp_sel, ~exp_seg, exp_fd}) begin
                n_bad++;
                $display("FAIL reset_mid cyc=%0d: sel=%b seg=%h fd=%b required sel=%b seg=%h fd=%b",
                         k, sel, seg, frame_done, exp_sel, exp_seg, exp_fd);
            end
            if (go) begin
                done = 1;
                $display("reset pulsed during SHOW of digit 2");
                n_cmp++;
                if (dut.shadow_reg !== '0 || sel !== 4'h0 || frame_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_mid_state: shadow=%h sel=%b fd=%b required 0/0000/0",
                             dut.shadow_reg, sel, frame_done);
                end
            end
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL reset_mid_bound: digit 2 never shown, required shown");
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_midframe_load();
        test_lz_blank();
        test_boundary_load();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
